osd_bitmap_writer: RTL and testbench
====================================

# osd_bitmap_writer

Packs 4-bit OSD pixel codes into 32-bit words and writes them into the OSD bitmap RAM through its write port (waddr/wdata/wreq, address step 1 per word). It is the producer for the video-side OSD overlay reader, which consumes the same RAM as 4-bit-per-pixel, pixel-0-in-LSB data. It supports two operations: streaming a bitmap from a pixel source with valid/ready handshake, and hardware-filling a word range with a constant colour code.

## Interface
- C_ADDR_WIDTH, 16: width of RAM word address.
- C_DEPTH, 32768: RAM depth in 32-bit words; addresses wrap at C_DEPTH.
- clk_in  in  1  clock; same clock as the RAM write port.
- rst  in  1  reset, synchronous, active-high.
- s_pix_i  in  4  pixel code (0..F).
- s_valid_i  in  1  pixel valid.
- s_last_i  in  1  marks the final pixel of a bitmap; qualified by s_valid_i.
- s_ready_o  out  1  pixel accepted when s_valid_i & s_ready_o.
- base_addr_i  in  C_ADDR_WIDTH  start word address, latched at operation start.
- fill_req_i  in  1  single-cycle fill request; honoured only in IDLE.
- fill_color_i  in  4  fill code, latched with fill_req_i.
- fill_words_i  in  16  number of words to fill, latched with fill_req_i.
- osd_waddr_o  out  C_ADDR_WIDTH  RAM word address.
- osd_wdata_o  out  32  RAM write data.
- osd_wreq_o  out  1  write strobe; one word per cycle high.
- busy_o  out  1  high in STREAM or FILL.
- done_o  out  1  one-cycle pulse at operation completion.
- words_o  out  16  words written by the current or last operation.
- overflow_o  out  1  sticky; set when address wraps C_DEPTH-1 -> 0.

## Operation
- States: IDLE, STREAM, FILL.
- IDLE: s_ready_o = ~fill_req_i. If fill_req_i is high, the block latches color, count, and base, then goes to FILL. Fill takes priority over a simultaneous s_valid_i. Otherwise, the first accepted pixel latches base_addr_i, clears words_o and overflow_o, and goes to STREAM.
- STREAM: s_ready_o = 1.
  - Accepted pixel n of a word goes to nibble [4n+3:4n], n = 0..7, pixel 0 in LSB.
  - On the 8th nibble, the block writes the word and then increments the address.
  - Accepted pixel with s_last_i: remaining nibbles are padded with 4'h0 and the word is written, even if partial. The block then returns to IDLE. A last pixel that lands on nibble 7 writes exactly one word, with no extra padding word.
  - fill_req_i is ignored.
- FILL: s_ready_o = 0. The block writes {8{fill_color}} to base, base+1, …, one word per cycle, fill_words words in total, then returns to IDLE. If fill_words_i = 0, no writes occur and done_o still pulses.
- Address arithmetic: modulo C_DEPTH. Stepping from C_DEPTH-1 wraps to 0 and sets overflow_o, which stays set until the next operation start or rst.
- words_o increments on every osd_wreq_o and saturates at FFFF.
- rst mid-operation: state goes to IDLE, the partial word is discarded, and no write is issued.

## Timing
- Reset values: osd_waddr_o=0, osd_wdata_o=0, osd_wreq_o=0, busy_o=0, done_o=0, words_o=0, overflow_o=0. s_ready_o is 0 while rst is high.
- osd_waddr_o, osd_wdata_o, osd_wreq_o, busy_o, done_o, words_o and overflow_o are registered. s_ready_o is combinational from state and fill_req_i.
- STREAM: the pixel that completes a word, accepted at edge N, gives osd_wreq_o high in cycle N+1 with that word's address and data.
- Throughput: 1 pixel/cycle sustained, so osd_wreq_o is high 1 cycle in 8.
- End of stream: done_o pulses in cycle N+2 after the last-pixel edge N. busy_o falls in the same cycle. The next operation may be accepted in cycle N+1.
- FILL: request sampled at edge N. Word k (k = 0..W-1) is written in cycle N+1+k. done_o pulses in cycle N+1+W. busy_o is high in cycles N+1 .. N+W. For W = 0, busy_o stays low and done_o pulses in cycle N+1.
- osd_wdata_o and osd_waddr_o hold their last value when osd_wreq_o is low.

## Configuration
- OSD_WRITER_MSB_FIRST_EN:
  - Defined: pixel n goes to nibble [31-4n:28-4n], pixel 0 in MSB, and padding fills the low nibbles.
  - Undefined (default): pixel 0 in LSB, matching the overlay reader.
  - Fill data is identical in both modes.

## Test plan
- Stream 16 pixels 1,2,…,F,0 with base=0x0010, s_last_i on the 16th -> writes 0x87654321 @0x0010 and 0x0FEDCBA9 @0x0011; done_o one cycle after the 2nd wreq; words_o=2.
- Stream 3 pixels A,B,C with s_last_i on C, base=0x0100 -> single write 0x00000CBA @0x0100.
- Fill color=4 words=5 base=0x7FFE (C_DEPTH=32768) -> writes 0x44444444 at 7FFE,7FFF,0000,0001,0002; overflow_o=1; done_o at cycle N+6.
- fill_req_i and s_valid_i high together in IDLE -> s_ready_o=0 that cycle, pixel not consumed, FILL runs; fill with words=0 -> no wreq, done_o at N+1.
- Stream with s_valid_i toggling 1/0 and rst asserted after 5 pixels -> no wreq, all outputs at reset values; new stream afterwards starts at nibble 0 of the new base.
- Build with OSD_WRITER_MSB_FIRST_EN, stream 1..8 -> write 0x12345678.

Source files
------------

// File: rtl/osd_bitmap_writer.sv
// OSD bitmap writer: packs 4-bit pixel codes into 32-bit RAM words, or fills a word range with one colour.
// Build macro OSD_WRITER_MSB_FIRST_EN places pixel 0 in the most significant nibble instead of the LSB.
module osd_bitmap_writer #(
   parameter int C_ADDR_WIDTH = 16,
   parameter int C_DEPTH      = 32768
) (
   input  logic                    clk_in,
   input  logic                    rst,
   input  logic [3:0]              s_pix_i,
   input  logic                    s_valid_i,
   input  logic                    s_last_i,
   output logic                    s_ready_o,
   input  logic [C_ADDR_WIDTH-1:0] base_addr_i,
   input  logic                    fill_req_i,
   input  logic [3:0]              fill_color_i,
   input  logic [15:0]             fill_words_i,
   output logic [C_ADDR_WIDTH-1:0] osd_waddr_o,
   output logic [31:0]             osd_wdata_o,
   output logic                    osd_wreq_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic [15:0]             words_o,
   output logic                    overflow_o
);
   typedef enum logic [1:0] {IDLE, STREAM, FILL} state_t;
   localparam logic [C_ADDR_WIDTH-1:0] LAST_ADDR = C_ADDR_WIDTH'(C_DEPTH - 1);

   state_t                  state_q, state_d;
   logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]             pack_q, pack_d;
   logic [2:0]              nib_q, nib_d;
   logic [3:0]              color_q, color_d;
   logic [15:0]             remain_q, remain_d;
   logic                    done_pend_q, done_pend_d;

   logic                    accept, take_pix, start, stream_end, done_now, do_write;
   logic [C_ADDR_WIDTH-1:0] wr_addr, waddr_d;
   logic [31:0]             wr_data, wdata_d, pix_word, packed_word;
   logic [15:0]             words_base, words_d;
   logic                    wreq_d, busy_d, done_d, ovf_d;

   always_comb begin
      s_ready_o = 1'b0;
      if (!rst) begin
         case (state_q)
            IDLE:    s_ready_o = ~fill_req_i;
            STREAM:  s_ready_o = 1'b1;
            default: s_ready_o = 1'b0;
         endcase
      end
   end

   assign accept = s_valid_i & s_ready_o;

   // Unfilled nibbles of pack_q are always zero, so OR-ing in the new pixel also pads a short last word.
   always_comb begin
`ifdef OSD_WRITER_MSB_FIRST_EN
      pix_word = {s_pix_i, 28'h0} >> {nib_q, 2'b00};
`else
      pix_word = {28'h0, s_pix_i} << {nib_q, 2'b00};
`endif
      packed_word = pack_q | pix_word;
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      pack_d      = pack_q;
      nib_d       = nib_q;
      color_d     = color_q;
      remain_d    = remain_q;
      done_pend_d = 1'b0;
      take_pix    = 1'b0;
      start       = 1'b0;
      stream_end  = 1'b0;
      done_now    = 1'b0;
      do_write    = 1'b0;
      wr_addr     = addr_q;
      wr_data     = osd_wdata_o;

      case (state_q)
         IDLE: begin
            if (fill_req_i) begin
               start   = 1'b1;
               color_d = fill_color_i;
               if (fill_words_i == 16'd0) begin
                  done_now = 1'b1;
               end else begin
                  do_write = 1'b1;
                  wr_addr  = base_addr_i;
                  wr_data  = {8{fill_color_i}};
                  remain_d = fill_words_i - 16'd1;
                  state_d  = FILL;
               end
            end else if (accept) begin
               start    = 1'b1;
               addr_d   = base_addr_i;
               wr_addr  = base_addr_i;
               take_pix = 1'b1;
            end
         end
         STREAM: begin
            take_pix = accept;
         end
         FILL: begin
            if (remain_q == 16'd0) begin
               state_d  = IDLE;
               done_now = 1'b1;
            end else begin
               do_write = 1'b1;
               wr_data  = {8{color_q}};
               remain_d = remain_q - 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (take_pix) begin
         state_d = STREAM;
         if (s_last_i || nib_q == 3'd7) begin
            do_write = 1'b1;
            wr_data  = packed_word;
            pack_d   = '0;
            nib_d    = '0;
         end else begin
            pack_d = packed_word;
            nib_d  = nib_q + 3'd1;
         end
         // Stream completion keeps busy for one more cycle and delays done, while IDLE already accepts work.
         if (s_last_i) begin
            state_d     = IDLE;
            stream_end  = 1'b1;
            done_pend_d = 1'b1;
         end
      end

      if (do_write) begin
         addr_d = (wr_addr == LAST_ADDR) ? '0 : wr_addr + C_ADDR_WIDTH'(1);
      end

      words_base = start ? 16'd0 : words_o;
      words_d    = (do_write && words_base != 16'hFFFF) ? words_base + 16'd1 : words_base;
      ovf_d      = (start ? 1'b0 : overflow_o) | (do_write && wr_addr == LAST_ADDR);
      wreq_d     = do_write;
      waddr_d    = do_write ? wr_addr : osd_waddr_o;
      wdata_d    = do_write ? wr_data : osd_wdata_o;
      busy_d     = (state_d != IDLE) | stream_end;
      done_d     = done_now | done_pend_q;
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         pack_q      <= '0;
         nib_q       <= '0;
         color_q     <= '0;
         remain_q    <= '0;
         done_pend_q <= 1'b0;
         osd_waddr_o <= '0;
         osd_wdata_o <= '0;
         osd_wreq_o  <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         words_o     <= '0;
         overflow_o  <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         pack_q      <= pack_d;
         nib_q       <= nib_d;
         color_q     <= color_d;
         remain_q    <= remain_d;
         done_pend_q <= done_pend_d;
         osd_waddr_o <= waddr_d;
         osd_wdata_o <= wdata_d;
         osd_wreq_o  <= wreq_d;
         busy_o      <= busy_d;
         done_o      <= done_d;
         words_o     <= words_d;
         overflow_o  <= ovf_d;
      end
   end
endmodule

// File: tb/tb_osd_bitmap_writer.sv
// Testbench for osd_bitmap_writer: directed cases plus randomized streams/fills against a word-level model.
// Expected pixel packing follows OSD_WRITER_MSB_FIRST_EN when the bench is built with that macro.
module tb_osd_bitmap_writer;
   localparam int C_ADDR_WIDTH = 16;
   localparam int C_DEPTH      = 32768;

   typedef struct {
      logic [15:0] addr;
      logic [31:0] data;
   } wr_t;

   logic        clk_in = 1'b0;
   logic        rst;
   logic [3:0]  s_pix_i;
   logic        s_valid_i;
   logic        s_last_i;
   logic        s_ready_o;
   logic [15:0] base_addr_i;
   logic        fill_req_i;
   logic [3:0]  fill_color_i;
   logic [15:0] fill_words_i;
   logic [15:0] osd_waddr_o;
   logic [31:0] osd_wdata_o;
   logic        osd_wreq_o;
   logic        busy_o;
   logic        done_o;
   logic [15:0] words_o;
   logic        overflow_o;

   wr_t        expQ[$];
   wr_t        gotQ[$];
   logic [3:0] pixBuf [0:255];
   int         vecCount = 0;
   int         errCount = 0;

   always #5 clk_in = ~clk_in;

   osd_bitmap_writer #(.C_ADDR_WIDTH(C_ADDR_WIDTH), .C_DEPTH(C_DEPTH)) dut (
      .clk_in(clk_in), .rst(rst),
      .s_pix_i(s_pix_i), .s_valid_i(s_valid_i), .s_last_i(s_last_i), .s_ready_o(s_ready_o),
      .base_addr_i(base_addr_i), .fill_req_i(fill_req_i), .fill_color_i(fill_color_i),
      .fill_words_i(fill_words_i), .osd_waddr_o(osd_waddr_o), .osd_wdata_o(osd_wdata_o),
      .osd_wreq_o(osd_wreq_o), .busy_o(busy_o), .done_o(done_o), .words_o(words_o),
      .overflow_o(overflow_o)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vecCount++;
      if (observed !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Word w of an n-pixel bitmap, built straight from the pixel list.
   function automatic logic [31:0] modelWord(input int w, input int n);
      logic [31:0] d;
      int idx;
      d = 32'h0;
      for (int j = 0; j < 8; j++) begin
         idx = 8 * w + j;
         if (idx < n) begin
`ifdef OSD_WRITER_MSB_FIRST_EN
            d = d | (32'(pixBuf[idx]) << (4 * (7 - j)));
`else
            d = d | (32'(pixBuf[idx]) << (4 * j));
`endif
         end
      end
      return d;
   endfunction

   // Every RAM write is logged and compared against the head of the expected-write queue.
   always @(negedge clk_in) begin
      if (osd_wreq_o === 1'b1) begin
         wr_t g;
         wr_t e;
         g.addr = osd_waddr_o;
         g.data = osd_wdata_o;
         gotQ.push_back(g);
         if (expQ.size() == 0) begin
            checkOutput("spurious_wreq", osd_wreq_o, 1'b0);
         end else begin
            e = expQ.pop_front();
            checkOutput("wr_addr", osd_waddr_o, e.addr);
            checkOutput("wr_data", osd_wdata_o, e.data);
         end
      end
   end

   task automatic applyStimulus(input int base, input int n, input int density);
      int  k;
      int  nw;
      int  guard;
      bit  valid;
      bit  prevWrite;
      bit  expOvf;
      wr_t e;
      nw = (n + 7) / 8;
      for (int w = 0; w < nw; w++) begin
         e.addr = 16'((base + w) % C_DEPTH);
         e.data = modelWord(w, n);
         expQ.push_back(e);
      end
      expOvf    = (base + nw >= C_DEPTH);
      k         = 0;
      guard     = 0;
      prevWrite = 1'b0;
      while (k < n && guard < 4000) begin
         valid        = ($urandom_range(0, 99) < density);
         s_valid_i    = valid;
         s_pix_i      = pixBuf[k];
         s_last_i     = (k == n - 1);
         fill_req_i   = (k > 0) && ($urandom_range(0, 3) == 0);
         fill_color_i = 4'($urandom);
         fill_words_i = 16'($urandom);
         base_addr_i  = (k == 0) ? 16'(base) : 16'($urandom_range(0, C_DEPTH - 1));
         @(negedge clk_in);
         checkOutput("wreq_timing", osd_wreq_o, prevWrite);
         checkOutput("stream_ready", s_ready_o, 1'b1);
         @(posedge clk_in);
         #1;
         prevWrite = valid && ((k % 8 == 7) || (k == n - 1));
         if (valid) k++;
         guard++;
      end
      if (k < n) checkOutput("stream_timeout", k, n);
      s_valid_i  = 1'b0;
      s_last_i   = 1'b0;
      fill_req_i = 1'b0;
      @(negedge clk_in);
      checkOutput("last_wreq", osd_wreq_o, prevWrite);
      checkOutput("done_early", done_o, 1'b0);
      checkOutput("busy_tail", busy_o, 1'b1);
      @(negedge clk_in);
      checkOutput("stream_done", done_o, 1'b1);
      checkOutput("busy_fall", busy_o, 1'b0);
      checkOutput("idle_wreq", osd_wreq_o, 1'b0);
      checkOutput("stream_words", words_o, nw);
      checkOutput("stream_overflow", overflow_o, expOvf);
      checkOutput("stream_pending", expQ.size(), 0);
      @(posedge clk_in);
      #1;
   endtask

   task automatic applyFill(input int base, input int color, input int w, input bit withPix);
      wr_t e;
      bit  expOvf;
      for (int k = 0; k < w; k++) begin
         e.addr = 16'((base + k) % C_DEPTH);
         e.data = 32'(color) * 32'h11111111;
         expQ.push_back(e);
      end
      expOvf       = (w > 0) && (base + w >= C_DEPTH);
      base_addr_i  = 16'(base);
      fill_color_i = 4'(color);
      fill_words_i = 16'(w);
      fill_req_i   = 1'b1;
      s_valid_i    = withPix;
      s_pix_i      = 4'($urandom);
      s_last_i     = 1'($urandom);
      @(negedge clk_in);
      checkOutput("fill_ready", s_ready_o, 1'b0);
      @(posedge clk_in);
      #1;
      fill_req_i   = 1'b0;
      s_valid_i    = 1'b0;
      s_last_i     = 1'b0;
      fill_color_i = 4'($urandom);
      fill_words_i = 16'($urandom);
      base_addr_i  = 16'($urandom);
      for (int k = 0; k < w; k++) begin
         @(negedge clk_in);
         checkOutput("fill_wreq", osd_wreq_o, 1'b1);
         checkOutput("fill_busy", busy_o, 1'b1);
         checkOutput("fill_done_early", done_o, 1'b0);
      end
      @(negedge clk_in);
      checkOutput("fill_done", done_o, 1'b1);
      checkOutput("fill_busy_end", busy_o, 1'b0);
      checkOutput("fill_wreq_end", osd_wreq_o, 1'b0);
      checkOutput("fill_words", words_o, w);
      checkOutput("fill_overflow", overflow_o, expOvf);
      checkOutput("fill_pending", expQ.size(), 0);
      @(posedge clk_in);
      #1;
   endtask

   initial begin
      int k;
      bit tog;
      rst          = 1'b1;
      s_pix_i      = 4'h0;
      s_valid_i    = 1'b0;
      s_last_i     = 1'b0;
      base_addr_i  = 16'h0;
      fill_req_i   = 1'b0;
      fill_color_i = 4'h0;
      fill_words_i = 16'h0;
      repeat (3) @(posedge clk_in);
      #1;
      @(negedge clk_in);
      checkOutput("rst_ready", s_ready_o, 1'b0);
      checkOutput("rst_waddr", osd_waddr_o, 16'h0);
      checkOutput("rst_wdata", osd_wdata_o, 32'h0);
      checkOutput("rst_wreq", osd_wreq_o, 1'b0);
      checkOutput("rst_busy", busy_o, 1'b0);
      checkOutput("rst_done", done_o, 1'b0);
      checkOutput("rst_words", words_o, 16'h0);
      checkOutput("rst_overflow", overflow_o, 1'b0);
      @(posedge clk_in);
      #1;
      rst = 1'b0;

      // Two full words from pixels 1..F,0.
      for (int i = 0; i < 16; i++) pixBuf[i] = 4'(i + 1);
      gotQ.delete();
      applyStimulus(16'h0010, 16, 100);
      checkOutput("t1_count", gotQ.size(), 2);
      if (gotQ.size() == 2) begin
`ifdef OSD_WRITER_MSB_FIRST_EN
         checkOutput("t1_word0", gotQ[0].data, 32'h12345678);
         checkOutput("t1_word1", gotQ[1].data, 32'h9ABCDEF0);
`else
         checkOutput("t1_word0", gotQ[0].data, 32'h87654321);
         checkOutput("t1_word1", gotQ[1].data, 32'h0FEDCBA9);
`endif
         checkOutput("t1_addr1", gotQ[1].addr, 16'h0011);
      end

      // Short partial word.
      pixBuf[0] = 4'hA;
      pixBuf[1] = 4'hB;
      pixBuf[2] = 4'hC;
      gotQ.delete();
      applyStimulus(16'h0100, 3, 100);
      checkOutput("t2_count", gotQ.size(), 1);
      if (gotQ.size() == 1) begin
`ifdef OSD_WRITER_MSB_FIRST_EN
         checkOutput("t2_word", gotQ[0].data, 32'hABC00000);
`else
         checkOutput("t2_word", gotQ[0].data, 32'h00000CBA);
`endif
         checkOutput("t2_addr", gotQ[0].addr, 16'h0100);
      end

      // Fill across the top of the RAM.
      gotQ.delete();
      applyFill(16'h7FFE, 4, 5, 1'b0);
      checkOutput("t3_count", gotQ.size(), 5);
      if (gotQ.size() == 5) begin
         checkOutput("t3_wrap_addr", gotQ[2].addr, 16'h0000);
         checkOutput("t3_wrap_data", gotQ[2].data, 32'h44444444);
      end
      checkOutput("t3_overflow", overflow_o, 1'b1);

      // Fill beats a simultaneous pixel; zero-length fill.
      applyFill(16'h0300, 7, 3, 1'b1);
      applyFill(16'h0400, 9, 0, 1'b1);

      // Reset in the middle of a stream after five accepted pixels.
      k   = 0;
      tog = 1'b1;
      base_addr_i = 16'h0600;
      while (k < 5) begin
         s_valid_i = tog;
         s_pix_i   = 4'($urandom);
         s_last_i  = 1'b0;
         @(posedge clk_in);
         #1;
         if (tog) k++;
         tog = ~tog;
      end
      rst       = 1'b1;
      s_valid_i = 1'b1;
      @(negedge clk_in);
      checkOutput("rst_mid_ready", s_ready_o, 1'b0);
      @(posedge clk_in);
      #1;
      @(negedge clk_in);
      checkOutput("rst_mid_waddr", osd_waddr_o, 16'h0);
      checkOutput("rst_mid_wdata", osd_wdata_o, 32'h0);
      checkOutput("rst_mid_busy", busy_o, 1'b0);
      checkOutput("rst_mid_words", words_o, 16'h0);
      checkOutput("rst_mid_overflow", overflow_o, 1'b0);
      @(posedge clk_in);
      #1;
      rst       = 1'b0;
      s_valid_i = 1'b0;
      for (int i = 0; i < 8; i++) pixBuf[i] = 4'(i + 1);
      gotQ.delete();
      applyStimulus(16'h0200, 8, 100);
      checkOutput("t5_count", gotQ.size(), 1);
      if (gotQ.size() == 1) begin
`ifdef OSD_WRITER_MSB_FIRST_EN
         checkOutput("t5_word", gotQ[0].data, 32'h12345678);
`else
         checkOutput("t5_word", gotQ[0].data, 32'h87654321);
`endif
         checkOutput("t5_addr", gotQ[0].addr, 16'h0200);
      end

      // Randomized mix of streams and fills with idle gaps.
      for (int t = 0; t < 24; t++) begin
         if ($urandom_range(0, 2) != 0) begin
            int n;
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) pixBuf[i] = 4'($urandom);
            applyStimulus($urandom_range(0, 16'h6000), n, $urandom_range(40, 100));
         end else begin
            applyFill($urandom_range(0, 16'h6000), $urandom_range(0, 15), $urandom_range(0, 12),
                      1'($urandom));
         end
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk_in);
            #1;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end
endmodule
